// File: rtl/pa_fpu_frbus.sv
// FPU write-back bus: oldest-first arbitration of EX2/EX3/EX4 results into a
// one-entry RTU write-back slot, plus sticky exception-flag accumulation.
module pa_fpu_frbus #(
  parameter int DATA_WIDTH  = 64,
  parameter int PREG_WIDTH  = 5,
  parameter int FFLAG_WIDTH = 5
) (
  input  logic                   ex2_ctrl_clk,
  input  logic                   cpurst_b,
  input  logic                   ctrl_frbus_ex2_wb_req,
  input  logic                   ctrl_frbus_ex3_wb_req,
  input  logic                   ctrl_frbus_ex4_wb_req,
  input  logic                   ctrl_xx_ex2_cancel,
  input  logic [DATA_WIDTH-1:0]  ex2_frbus_data,
  input  logic [DATA_WIDTH-1:0]  ex3_frbus_data,
  input  logic [DATA_WIDTH-1:0]  ex4_frbus_data,
  input  logic [PREG_WIDTH-1:0]  ex2_frbus_preg,
  input  logic [PREG_WIDTH-1:0]  ex3_frbus_preg,
  input  logic [PREG_WIDTH-1:0]  ex4_frbus_preg,
  input  logic [FFLAG_WIDTH-1:0] ex2_frbus_fflags,
  input  logic [FFLAG_WIDTH-1:0] ex3_frbus_fflags,
  input  logic [FFLAG_WIDTH-1:0] ex4_frbus_fflags,
  input  logic                   rtu_fpu_wb_ready,
  input  logic                   cp0_fpu_fflags_clr,
  output logic                   frbus_ctrl_ex2_wb_grant,
  output logic                   frbus_ctrl_ex3_wb_grant,
  output logic                   frbus_ctrl_ex4_wb_grant,
  output logic                   fpu_rtu_wb_vld,
  output logic [DATA_WIDTH-1:0]  fpu_rtu_wb_data,
  output logic [PREG_WIDTH-1:0]  fpu_rtu_wb_preg,
  output logic [FFLAG_WIDTH-1:0] fpu_rtu_wb_fflags,
  output logic [FFLAG_WIDTH-1:0] fpu_cp0_fflags,
  output logic                   frbus_ctrl_clk_en,
  output logic                   frbus_xx_busy
);

  logic                   wb_vld_q,    wb_vld_d;
  logic [DATA_WIDTH-1:0]  wb_data_q,   wb_data_d;
  logic [PREG_WIDTH-1:0]  wb_preg_q,   wb_preg_d;
  logic [FFLAG_WIDTH-1:0] wb_fflags_q, wb_fflags_d;
  logic [FFLAG_WIDTH-1:0] sticky_q,    sticky_d;

  logic accept_s;
  logic handshake_s;
  logic ex2_grant_s;
  logic ex3_grant_s;
  logic ex4_grant_s;

  assign accept_s    = !wb_vld_q || rtu_fpu_wb_ready;
  assign handshake_s = wb_vld_q && rtu_fpu_wb_ready;

  // Oldest-first grant selection; grants are held low while in reset.
  always_comb begin
    ex4_grant_s = 1'b0;
    ex3_grant_s = 1'b0;
    ex2_grant_s = 1'b0;
    if (cpurst_b && accept_s) begin
      ex4_grant_s = ctrl_frbus_ex4_wb_req;
      ex3_grant_s = ctrl_frbus_ex3_wb_req && !ctrl_frbus_ex4_wb_req;
      ex2_grant_s = ctrl_frbus_ex2_wb_req && !ctrl_xx_ex2_cancel
                    && !ctrl_frbus_ex3_wb_req && !ctrl_frbus_ex4_wb_req;
    end else begin
      ex4_grant_s = 1'b0;
      ex3_grant_s = 1'b0;
      ex2_grant_s = 1'b0;
    end
  end

  // Slot next state: a grant refills (even while draining), a lone drain empties it.
  always_comb begin
    wb_vld_d    = wb_vld_q;
    wb_data_d   = wb_data_q;
    wb_preg_d   = wb_preg_q;
    wb_fflags_d = wb_fflags_q;
    if (ex4_grant_s) begin
      wb_vld_d    = 1'b1;
      wb_data_d   = ex4_frbus_data;
      wb_preg_d   = ex4_frbus_preg;
      wb_fflags_d = ex4_frbus_fflags;
    end else if (ex3_grant_s) begin
      wb_vld_d    = 1'b1;
      wb_data_d   = ex3_frbus_data;
      wb_preg_d   = ex3_frbus_preg;
      wb_fflags_d = ex3_frbus_fflags;
    end else if (ex2_grant_s) begin
      wb_vld_d    = 1'b1;
      wb_data_d   = ex2_frbus_data;
      wb_preg_d   = ex2_frbus_preg;
      wb_fflags_d = ex2_frbus_fflags;
    end else if (handshake_s) begin
      wb_vld_d    = 1'b0;
    end else begin
      wb_vld_d    = wb_vld_q;
    end
  end

  // Sticky flags: clear takes effect before the completed handshake ORs in.
  always_comb begin
    sticky_d = sticky_q;
    if (cp0_fpu_fflags_clr) begin
      sticky_d = {FFLAG_WIDTH{1'b0}};
    end else begin
      sticky_d = sticky_q;
    end
    if (handshake_s) begin
      sticky_d = sticky_d | wb_fflags_q;
    end else begin
      sticky_d = sticky_d;
    end
  end

  // State registers; reset discards any in-flight slot entry.
  always_ff @(posedge ex2_ctrl_clk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      wb_vld_q    <= 1'b0;
      wb_data_q   <= {DATA_WIDTH{1'b0}};
      wb_preg_q   <= {PREG_WIDTH{1'b0}};
      wb_fflags_q <= {FFLAG_WIDTH{1'b0}};
      sticky_q    <= {FFLAG_WIDTH{1'b0}};
    end else begin
      wb_vld_q    <= wb_vld_d;
      wb_data_q   <= wb_data_d;
      wb_preg_q   <= wb_preg_d;
      wb_fflags_q <= wb_fflags_d;
      sticky_q    <= sticky_d;
    end
  end

  assign frbus_ctrl_ex2_wb_grant = ex2_grant_s;
  assign frbus_ctrl_ex3_wb_grant = ex3_grant_s;
  assign frbus_ctrl_ex4_wb_grant = ex4_grant_s;
  assign fpu_rtu_wb_vld          = wb_vld_q;
  assign fpu_rtu_wb_data         = wb_data_q;
  assign fpu_rtu_wb_preg         = wb_preg_q;
  assign fpu_rtu_wb_fflags       = wb_fflags_q;
  assign fpu_cp0_fflags          = sticky_q;
  // Keeps the shared clock running while EX3/EX4 or the slot still need edges.
  assign frbus_ctrl_clk_en       = ctrl_frbus_ex2_wb_req || ctrl_frbus_ex3_wb_req
                                   || ctrl_frbus_ex4_wb_req || wb_vld_q;
  assign frbus_xx_busy           = wb_vld_q;

endmodule

// File: tb/tb_pa_fpu_frbus.sv
// Bench for pa_fpu_frbus: directed scenarios followed by random traffic, all
// checked against a transaction-level model of the write-back slot.
module tb_pa_fpu_frbus;

  logic        clk = 1'b0;
  logic        cpurst_b;
  logic        req2, req3, req4, cancel, ready, clr;
  logic [63:0] d2, d3, d4;
  logic [4:0]  p2, p3, p4, f2, f3, f4;
  logic        g2, g3, g4, vld, clk_en, busy;
  logic [63:0] wdata;
  logic [4:0]  wpreg, wff, cpff;

  int total = 0;
  int bad   = 0;

  // model of the slot and sticky flags
  logic        m_vld;
  logic [63:0] m_data;
  logic [4:0]  m_preg, m_ff, m_sticky;

  always #5 clk = ~clk;

  pa_fpu_frbus dut (
    .ex2_ctrl_clk(clk), .cpurst_b(cpurst_b),
    .ctrl_frbus_ex2_wb_req(req2), .ctrl_frbus_ex3_wb_req(req3),
    .ctrl_frbus_ex4_wb_req(req4), .ctrl_xx_ex2_cancel(cancel),
    .ex2_frbus_data(d2), .ex3_frbus_data(d3), .ex4_frbus_data(d4),
    .ex2_frbus_preg(p2), .ex3_frbus_preg(p3), .ex4_frbus_preg(p4),
    .ex2_frbus_fflags(f2), .ex3_frbus_fflags(f3), .ex4_frbus_fflags(f4),
    .rtu_fpu_wb_ready(ready), .cp0_fpu_fflags_clr(clr),
    .frbus_ctrl_ex2_wb_grant(g2), .frbus_ctrl_ex3_wb_grant(g3),
    .frbus_ctrl_ex4_wb_grant(g4), .fpu_rtu_wb_vld(vld),
    .fpu_rtu_wb_data(wdata), .fpu_rtu_wb_preg(wpreg),
    .fpu_rtu_wb_fflags(wff), .fpu_cp0_fflags(cpff),
    .frbus_ctrl_clk_en(clk_en), .frbus_xx_busy(busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: check everything at the negedge, then advance the model at the posedge.
  task automatic cycle();
    int  w;
    logic hs;
    @(negedge clk);
    if (!cpurst_b) begin
      m_vld = 1'b0; m_data = 64'd0; m_preg = 5'd0; m_ff = 5'd0; m_sticky = 5'd0;
    end
    w = 0;
    if (cpurst_b && (!m_vld || ready)) begin
      if (req4)                 w = 4;
      else if (req3)            w = 3;
      else if (req2 && !cancel) w = 2;
    end
    chk("grant4", {63'd0, g4}, {63'd0, (w == 4)});
    chk("grant3", {63'd0, g3}, {63'd0, (w == 3)});
    chk("grant2", {63'd0, g2}, {63'd0, (w == 2)});
    chk("wb_vld", {63'd0, vld}, {63'd0, m_vld});
    chk("wb_data", wdata, m_data);
    chk("wb_preg", {59'd0, wpreg}, {59'd0, m_preg});
    chk("wb_fflags", {59'd0, wff}, {59'd0, m_ff});
    chk("cp0_fflags", {59'd0, cpff}, {59'd0, m_sticky});
    chk("clk_en", {63'd0, clk_en}, {63'd0, (req2 | req3 | req4 | m_vld)});
    chk("busy", {63'd0, busy}, {63'd0, m_vld});
    @(posedge clk);
    if (cpurst_b) begin
      hs = m_vld && ready;
      if (clr) m_sticky = 5'd0;
      if (hs)  m_sticky = m_sticky | m_ff;
      case (w)
        4:       begin m_vld = 1'b1; m_data = d4; m_preg = p4; m_ff = f4; end
        3:       begin m_vld = 1'b1; m_data = d3; m_preg = p3; m_ff = f3; end
        2:       begin m_vld = 1'b1; m_data = d2; m_preg = p2; m_ff = f2; end
        default: if (hs) m_vld = 1'b0;
      endcase
    end
    #1;
  endtask

  initial begin
    m_vld = 1'b0; m_data = 64'd0; m_preg = 5'd0; m_ff = 5'd0; m_sticky = 5'd0;
    cpurst_b = 1'b0; cancel = 1'b0; ready = 1'b1; clr = 1'b0;
    req2 = 1'b1; req3 = 1'b1; req4 = 1'b1;
    d2 = 64'h2222_0000_0000_0002; d3 = 64'h3333_0000_0000_0003; d4 = 64'h4444_0000_0000_0004;
    p2 = 5'd2; p3 = 5'd3; p4 = 5'd4;
    f2 = 5'h00; f3 = 5'h00; f4 = 5'h00;

    // reset with all requests high
    cycle(); cycle();
    chk("rst_cp0", {59'd0, cpff}, 64'h0);
    chk("rst_vld", {63'd0, vld}, 64'h0);
    cpurst_b = 1'b1;

    // all three requesting, each dropped after its grant
    cycle(); req4 = 1'b0;
    chk("seq_preg4", {59'd0, wpreg}, 64'd4);
    cycle(); req3 = 1'b0;
    chk("seq_preg3", {59'd0, wpreg}, 64'd3);
    cycle(); req2 = 1'b0;
    chk("seq_preg2", {59'd0, wpreg}, 64'd2);
    chk("seq_vld", {63'd0, vld}, 64'd1);
    cycle();

    // backpressure holds the slot and blocks EX3
    d4 = 64'h3FF0_0000_0000_0000; req4 = 1'b1;
    cycle(); req4 = 1'b0; ready = 1'b0; req3 = 1'b1; d3 = 64'h4000_0000_0000_0000;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("stall_data", wdata, 64'h3FF0_0000_0000_0000);
    end
    ready = 1'b1;
    cycle(); req3 = 1'b0;
    chk("refill_data", wdata, 64'h4000_0000_0000_0000);
    chk("refill_vld", {63'd0, vld}, 64'd1);
    cycle();

    // cancelled EX2 never wins
    req2 = 1'b1; cancel = 1'b1;
    cycle(); cycle();
    chk("cancel_vld", {63'd0, vld}, 64'd0);
    req2 = 1'b0; cancel = 1'b0;

    // sticky flag accumulation and clear-with-handshake
    clr = 1'b1; cycle(); clr = 1'b0;
    f4 = 5'h01; req4 = 1'b1; cycle();
    f4 = 5'h10; cycle(); req4 = 1'b0;
    cycle(); cycle();
    chk("sticky_or", {59'd0, cpff}, 64'h11);
    f4 = 5'h04; req4 = 1'b1; cycle();
    req4 = 1'b0; clr = 1'b1; cycle(); clr = 1'b0;
    chk("sticky_clr_hs", {59'd0, cpff}, 64'h04);

    // clock-enable request
    req4 = 1'b1; #1;
    chk("clk_en_req", {63'd0, clk_en}, 64'd1);
    cycle(); req4 = 1'b0;
    cycle(); #1;
    chk("clk_en_idle", {63'd0, clk_en}, 64'd0);
    chk("busy_idle", {63'd0, busy}, 64'd0);

    // random traffic, with an occasional reset mid-transfer
    for (int i = 0; i < 300; i++) begin
      req2 = 1'($urandom_range(0, 1)); req3 = 1'($urandom_range(0, 1));
      req4 = 1'($urandom_range(0, 2) == 0); cancel = 1'($urandom_range(0, 3) == 0);
      ready = 1'($urandom_range(0, 3) != 0); clr = 1'($urandom_range(0, 9) == 0);
      d2 = {$urandom, $urandom}; d3 = {$urandom, $urandom}; d4 = {$urandom, $urandom};
      p2 = 5'($urandom); p3 = 5'($urandom); p4 = 5'($urandom);
      f2 = 5'($urandom); f3 = 5'($urandom); f4 = 5'($urandom);
      cpurst_b = !(i == 150 || i == 151);
      cycle();
    end
    cpurst_b = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
